// File: rtl/pc_redirect_unit_if.sv
// Jump redirect handshake between decode and the fetch PC owner.
// Decode is the master: it presents a resolved jump and holds it until ready.
interface pc_redirect_unit_if #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5
);
  logic               i_jump_valid;
  logic [1:0]         i_jump;
  logic [NB_DATA-1:0] i_pc_jump;
  logic [NB_DATA-1:0] i_pc_next;
  logic [NB_REG-1:0]  i_rd;
  logic               o_jump_ready;

  modport master (
    output i_jump_valid,
    output i_jump,
    output i_pc_jump,
    output i_pc_next,
    output i_rd,
    input  o_jump_ready
  );

  modport slave (
    input  i_jump_valid,
    input  i_jump,
    input  i_pc_jump,
    input  i_pc_next,
    input  i_rd,
    output o_jump_ready
  );
endinterface

// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: advance, jump redirect, link writeback, misalignment fault.
// Define DELAY_SLOT_EN for MIPS branch-delay-slot semantics.
module pc_redirect_unit #(
  parameter int                 NB_DATA  = 32,
  parameter int                 NB_REG   = 5,
  parameter logic [NB_DATA-1:0] RESET_PC = '0
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_stall,
  pc_redirect_unit_if.slave  jmp,
  output logic [NB_DATA-1:0] o_pc,
  output logic [NB_DATA-1:0] o_pc_next,
  output logic               o_flush,
  output logic               o_link_we,
  output logic [NB_REG-1:0]  o_link_addr,
  output logic [NB_DATA-1:0] o_link_data,
  output logic               o_misaligned
);

  localparam logic [1:0] JMP_J    = 2'b00;
  localparam logic [1:0] JMP_JAL  = 2'b01;
  localparam logic [1:0] JMP_JALR = 2'b10;

  localparam logic [NB_DATA-1:0] STEP = NB_DATA'(4);
  localparam logic [NB_REG-1:0]  RA   = NB_REG'(31);

`ifdef DELAY_SLOT_EN
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SLOT  = 2'd1,
    FAULT = 2'd2
  } state_t;
  localparam logic [NB_DATA-1:0] LINK_OFS = STEP;
`else
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FAULT = 2'd2
  } state_t;
  localparam logic [NB_DATA-1:0] LINK_OFS = '0;
`endif

  state_t             state_q;
  state_t             state_d;
  logic [NB_DATA-1:0] pc_d;
  logic               flush_d;
  logic               we_d;
  logic [NB_REG-1:0]  addr_d;
  logic [NB_DATA-1:0] data_d;
  logic               mis_d;

`ifdef DELAY_SLOT_EN
  logic [NB_DATA-1:0] tgt_q;
  logic [NB_DATA-1:0] tgt_d;
`endif

  logic adv;
  logic ready;
  logic acc;
  logic misal;
  logic is_link;

  assign adv     = i_enable & ~i_stall & (state_q != FAULT);
  assign ready   = adv & (state_q == RUN);
  assign acc     = jmp.i_jump_valid & ready;
  assign misal   = |jmp.i_pc_jump[1:0];
  assign is_link = (jmp.i_jump == JMP_JAL) |
                   (jmp.i_jump == JMP_JALR);

  assign jmp.o_jump_ready = ready;
  assign o_pc_next        = o_pc + STEP;

  always_comb begin
    state_d = state_q;
    pc_d    = o_pc;
    flush_d = 1'b0;
    we_d    = 1'b0;
    addr_d  = o_link_addr;
    data_d  = o_link_data;
    mis_d   = o_misaligned;
`ifdef DELAY_SLOT_EN
    tgt_d   = tgt_q;
`endif
    unique case (state_q)
      RUN: begin
        if (acc && misal) begin
          state_d = FAULT;
          mis_d   = 1'b1;
        end else if (acc) begin
          if (is_link) begin
            we_d   = 1'b1;
            addr_d = (jmp.i_jump == JMP_JAL) ? RA : jmp.i_rd;
            data_d = jmp.i_pc_next + LINK_OFS;
          end
`ifdef DELAY_SLOT_EN
          // the slot instruction at pc+4 still runs before the target
          tgt_d   = jmp.i_pc_jump;
          pc_d    = o_pc + STEP;
          state_d = SLOT;
`else
          pc_d    = jmp.i_pc_jump;
          flush_d = 1'b1;
`endif
        end else if (adv) begin
          pc_d = o_pc + STEP;
        end
      end
`ifdef DELAY_SLOT_EN
      SLOT: begin
        if (adv) begin
          pc_d    = tgt_q;
          state_d = RUN;
        end
      end
`endif
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= RUN;
      o_pc         <= RESET_PC;
      o_flush      <= 1'b0;
      o_link_we    <= 1'b0;
      o_link_addr  <= '0;
      o_link_data  <= '0;
      o_misaligned <= 1'b0;
`ifdef DELAY_SLOT_EN
      tgt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      o_pc         <= pc_d;
      o_flush      <= flush_d;
      o_link_we    <= we_d;
      o_link_addr  <= addr_d;
      o_link_data  <= data_d;
      o_misaligned <= mis_d;
`ifdef DELAY_SLOT_EN
      tgt_q        <= tgt_d;
`endif
    end
  end

  unused_jmp_j: assert property (@(posedge i_clock) 1'b1 || (jmp.i_jump == JMP_J));

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Bench for pc_redirect_unit: vector table, directed corners, random vs model.
// Follows DELAY_SLOT_EN the same way the design does.
module tb_pc_redirect_unit;

  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, en, stall;
  logic [31:0] pc, pc_next, link_data;
  logic        flush, link_we, mis;
  logic [4:0]  link_addr;

  pc_redirect_unit_if #(.NB_DATA(32), .NB_REG(5)) jif ();

  pc_redirect_unit #(
    .NB_DATA (32),
    .NB_REG  (5),
    .RESET_PC(RESET_PC)
  ) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_enable    (en),
    .i_stall     (stall),
    .jmp         (jif.slave),
    .o_pc        (pc),
    .o_pc_next   (pc_next),
    .o_flush     (flush),
    .o_link_we   (link_we),
    .o_link_addr (link_addr),
    .o_link_data (link_data),
    .o_misaligned(mis)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model: PC value, queue of targets waiting behind a slot
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  bit          m_fault, m_flush, m_we, m_acc;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  function automatic bit m_ready();
    return en && !stall && !m_fault && (m_q.size() == 0);
  endfunction

  task automatic model_update();
    bit rdy;
    rdy     = m_ready();
    m_acc   = jif.i_jump_valid && rdy;
    m_flush = 0;
    m_we    = 0;
    if (rst) begin
      m_pc    = RESET_PC;
      m_q.delete();
      m_fault = 0;
      m_addr  = 0;
      m_data  = 0;
      m_acc   = 0;
    end else if (m_acc) begin
      if (jif.i_pc_jump % 4 != 0) begin
        m_fault = 1;
      end else begin
        if (jif.i_jump == 2'b01 || jif.i_jump == 2'b10) begin
          m_we   = 1;
          m_addr = (jif.i_jump == 2'b01) ? 5'd31 : jif.i_rd;
          m_data = jif.i_pc_next + (DS ? 32'd4 : 32'd0);
        end
        if (DS) begin
          m_q.push_back(jif.i_pc_jump);
          m_pc = m_pc + 32'd4;
        end else begin
          m_pc    = jif.i_pc_jump;
          m_flush = 1;
        end
      end
    end else if (en && !stall && !m_fault) begin
      if (m_q.size() != 0) m_pc = m_q.pop_front();
      else m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " pc"},      pc,        m_pc);
    check({tag, " pc_next"}, pc_next,   m_pc + 32'd4);
    check({tag, " flush"},   flush,     m_flush);
    check({tag, " link_we"}, link_we,   m_we);
    check({tag, " addr"},    link_addr, m_addr);
    check({tag, " data"},    link_data, m_data);
    check({tag, " mis"},     mis,       m_fault);
  endtask

  task automatic step(input bit chk, input string tag);
    #1;
    if (chk) check({tag, " ready"}, jif.o_jump_ready, m_ready());
    model_update();
    @(posedge clk);
    #1;
    if (chk) check_model(tag);
  endtask

  task automatic drive(input logic r, input logic e, input logic s,
                       input logic v, input logic [1:0] j,
                       input logic [31:0] t, input logic [31:0] pn,
                       input logic [4:0] rd);
    rst              = r;
    en               = e;
    stall            = s;
    jif.i_jump_valid = v;
    jif.i_jump       = j;
    jif.i_pc_jump    = t;
    jif.i_pc_next    = pn;
    jif.i_rd         = rd;
  endtask

  typedef struct {
    logic        rst, en, stall, valid;
    logic [1:0]  jump;
    logic [31:0] tgt, pn;
    logic [4:0]  rd;
    logic        rdy;
    logic [31:0] pc;
    logic        fl, we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        mis;
  } vec_t;

  function automatic vec_t mk(
    input logic r, input logic e, input logic s, input logic v,
    input logic [1:0] j, input logic [31:0] t, input logic [31:0] pn,
    input logic [4:0] rd, input logic rdy, input logic [31:0] p,
    input logic fl, input logic we, input logic [4:0] a,
    input logic [31:0] d, input logic m);
    vec_t x;
    x.rst = r;  x.en = e;   x.stall = s; x.valid = v;
    x.jump = j; x.tgt = t;  x.pn = pn;   x.rd = rd;
    x.rdy = rdy; x.pc = p;  x.fl = fl;   x.we = we;
    x.addr = a; x.data = d; x.mis = m;
    return x;
  endfunction

  vec_t tbl[19];

  logic [31:0] d1, d2, r32, r32b;
  logic [1:0]  lo;

  initial begin
    d1 = DS ? 32'h18 : 32'h14;
    d2 = DS ? 32'h4C : 32'h48;
    tbl[0]  = mk(1,0,0,0,2'd0,0,0,0, 0, 32'h0, 0,0,0,0,0);
    tbl[1]  = mk(0,1,0,0,2'd0,0,0,0, 1, 32'h4, 0,0,0,0,0);
    tbl[2]  = mk(0,1,0,0,2'd0,0,0,0, 1, 32'h8, 0,0,0,0,0);
    tbl[3]  = mk(0,1,0,0,2'd0,0,0,0, 1, 32'hC, 0,0,0,0,0);
    tbl[4]  = mk(0,1,0,1,2'd2,32'h40,32'h14,5, 1,
                 DS ? 32'h10 : 32'h40, !DS, 1, 5, d1, 0);
    tbl[5]  = mk(0,1,0,0,2'd0,0,0,0, !DS,
                 DS ? 32'h40 : 32'h44, 0,0,5,d1,0);
    for (int i = 6; i <= 8; i++)
      tbl[i] = mk(0,1,1,1,2'd1,32'h80,32'h48,0, 0,
                  DS ? 32'h40 : 32'h44, 0,0,5,d1,0);
    tbl[9]  = mk(0,1,0,1,2'd1,32'h80,32'h48,0, 1,
                 DS ? 32'h44 : 32'h80, !DS, 1, 31, d2, 0);
    tbl[10] = mk(0,1,0,0,2'd0,0,0,0, !DS,
                 DS ? 32'h80 : 32'h84, 0,0,31,d2,0);
    tbl[11] = mk(0,0,0,0,2'd0,0,0,0, 0,
                 DS ? 32'h80 : 32'h84, 0,0,31,d2,0);
    tbl[12] = mk(0,1,0,1,2'd0,32'h200,0,0, 1,
                 DS ? 32'h84 : 32'h200, !DS, 0, 31, d2, 0);
    tbl[13] = mk(0,1,0,0,2'd0,0,0,0, !DS,
                 DS ? 32'h200 : 32'h204, 0,0,31,d2,0);
    tbl[14] = mk(0,1,0,1,2'd3,32'h102,0,0, 1,
                 DS ? 32'h200 : 32'h204, 0,0,31,d2,1);
    tbl[15] = mk(0,1,0,0,2'd0,0,0,0, 0,
                 DS ? 32'h200 : 32'h204, 0,0,31,d2,1);
    tbl[16] = mk(0,1,0,1,2'd3,32'h102,0,0, 0,
                 DS ? 32'h200 : 32'h204, 0,0,31,d2,1);
    tbl[17] = mk(1,0,0,0,2'd0,0,0,0, 0, 32'h0, 0,0,0,0,0);
    tbl[18] = mk(0,1,0,0,2'd0,0,0,0, 1, 32'h4, 0,0,0,0,0);

    m_pc = RESET_PC; m_fault = 0; m_flush = 0; m_we = 0;
    m_acc = 0; m_addr = 0; m_data = 0; m_q.delete();

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].stall, tbl[i].valid,
            tbl[i].jump, tbl[i].tgt, tbl[i].pn, tbl[i].rd);
      #1;
      check($sformatf("row%0d ready", i), jif.o_jump_ready, tbl[i].rdy);
      step(0, "");
      check($sformatf("row%0d pc", i),      pc,        tbl[i].pc);
      check($sformatf("row%0d pc_next", i), pc_next,   tbl[i].pc + 32'd4);
      check($sformatf("row%0d flush", i),   flush,     tbl[i].fl);
      check($sformatf("row%0d link_we", i), link_we,   tbl[i].we);
      check($sformatf("row%0d addr", i),    link_addr, tbl[i].addr);
      check($sformatf("row%0d data", i),    link_data, tbl[i].data);
      check($sformatf("row%0d mis", i),     mis,       tbl[i].mis);
    end

    // wrap-around from the top of the address space
    drive(0,1,0,1,2'd3,32'hFFFF_FFFC,0,0);
    step(1, "wrap jr");
    drive(0,1,0,0,2'd0,0,0,0);
    for (int k = 0; k < 4 && pc !== 32'hFFFF_FFFC; k++) step(1, "wrap run");
    check("wrap top pc", pc, 32'hFFFF_FFFC);
    check("wrap pc_next", pc_next, 32'h0);
    step(1, "wrap adv");
    check("wrap pc", pc, 32'h0);

`ifdef DELAY_SLOT_EN
    drive(0,1,0,1,2'd0,32'h1C,0,0);
    step(1, "ds j");
    drive(0,1,0,0,2'd0,0,0,0);
    step(1, "ds slot");
    step(1, "ds run");
    check("ds start pc", pc, 32'h20);
    drive(0,1,0,1,2'd1,32'h100,32'h1C,0);
    step(1, "ds jal");
    check("ds jal pc", pc, 32'h24);
    check("ds jal we", link_we, 1'b1);
    check("ds jal addr", link_addr, 5'd31);
    check("ds jal data", link_data, 32'h20);
    drive(0,1,0,0,2'd0,0,0,0);
    step(1, "ds tgt");
    check("ds tgt pc", pc, 32'h100);
    check("ds tgt we", link_we, 1'b0);
    drive(0,1,0,1,2'd1,32'h300,32'h10,0);
    step(1, "ds jal2");
    drive(1,1,0,0,2'd0,0,0,0);
    step(1, "ds rst");
    check("ds rst pc", pc, RESET_PC);
    drive(0,1,0,0,2'd0,0,0,0);
    step(1, "ds post");
    check("ds post pc", pc, RESET_PC + 32'd4);
`endif

    for (int n = 0; n < 600; n++) begin
      rst   = ($urandom_range(0, 39) == 0);
      en    = ($urandom_range(0, 9) != 0);
      stall = ($urandom_range(0, 4) == 0);
      if (!(jif.i_jump_valid && !m_acc)) begin
        r32  = $urandom;
        r32b = $urandom;
        lo   = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        jif.i_jump_valid = ($urandom_range(0, 2) == 0);
        jif.i_jump       = 2'($urandom_range(0, 3));
        jif.i_pc_jump    = {r32[31:2], lo};
        jif.i_pc_next    = {r32b[31:2], 2'b00};
        jif.i_rd         = 5'($urandom_range(0, 31));
      end
      step(1, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
